apb_master_bridge: RTL
======================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter APB_START, default 32'h4000_0000, lowest APB-mapped address.
REQ-002 SHALL have parameter APB_END, default 32'h7FFF_FFFF, highest APB-mapped address.
REQ-003 SHALL have parameter TIMEOUT, default 16, max ACCESS cycles with PREADY low (legal 2..255).
REQ-004 SHALL have one clock and one synchronous, active-high reset; reset polarity and synchronicity are fixed.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 M_req_valid  input  1  master request valid.
REQ-008 M_req_ready  output  1  bridge accepts request.
REQ-009 M_write  input  1  1 = write, 0 = read.
REQ-010 M_addr  input  32  transaction address.
REQ-011 M_wdata  input  32  write data.
REQ-012 M_strb  input  4  write byte strobes.
REQ-013 M_rsp_valid  output  1  response valid.
REQ-014 M_rsp_ready  input  1  master accepts response.
REQ-015 M_rdata  output  32  read data, 0 on writes and errors.
REQ-016 M_err  output  1  response error flag.
REQ-017 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-018 PADDR  output  32;  PWDATA  output  32;  PSTRB  output  4  APB address and data.
REQ-019 PRDATA  input  32;  PREADY  input  1;  PSLVERR  input  1  APB completer response.

Function
REQ-020 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-021 SHALL drive M_req_ready=1 only in IDLE; handshake = M_req_valid & M_req_ready.
REQ-022 On handshake, SHALL register M_write, M_addr, M_wdata, M_strb; PADDR/PWRITE/PWDATA/PSTRB stay stable until leaving ACCESS.
REQ-023 Handshake with APB_START <= M_addr <= APB_END (inclusive) SHALL go to SETUP; otherwise SHALL go to RESP with M_err=1, M_rdata=0 and no PSEL assertion.
REQ-024 SETUP: PSEL=1, PENABLE=0, exactly one cycle, then ACCESS.
REQ-025 ACCESS: PSEL=1, PENABLE=1; on PREADY=1, SHALL capture PRDATA (reads only; writes give 0) and PSLVERR into M_rdata/M_err and go to RESP.
REQ-026 SHALL count consecutive ACCESS cycles with PREADY=0; when count reaches TIMEOUT, SHALL drop PSEL/PENABLE and go to RESP with M_err=1, M_rdata=0.
REQ-027 PREADY=1 in the same cycle the count reaches TIMEOUT SHALL complete normally (PREADY wins).
REQ-028 RESP: M_rsp_valid=1, M_rdata/M_err stable; on M_rsp_ready=1 SHALL return to IDLE; no new request accepted that cycle.
REQ-029 Latency for zero-wait completer: handshake in cycle N, SETUP N+1, ACCESS N+2, M_rsp_valid N+3.
REQ-030 Out-of-range latency: handshake in cycle N, M_rsp_valid N+1.
REQ-031 PSEL/PENABLE SHALL be 0 in IDLE and RESP; PENABLE SHALL never be 1 without PSEL.
REQ-032 Address compare SHALL be unsigned 32-bit; APB_END=32'hFFFF_FFFF SHALL not wrap.

Reset
REQ-033 On rst=1 at a clock edge, SHALL enter IDLE regardless of state, including mid-ACCESS (transaction dropped, no response).
REQ-034 Reset values: M_req_ready=1 once rst deasserted, M_rsp_valid=0, M_rdata=0, M_err=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, timeout count=0.
REQ-035 While rst=1, M_req_ready SHALL be 0.

Structure
REQ-036 State enum, APB_START/APB_END defaults and TIMEOUT default SHALL live in shared package apb_bridge_pkg, reused by the upstream address decoder.
REQ-037 Timeout counter SHALL be a sub-module apb_wdog (inputs: clear, count enable; output: expired).

Verification
REQ-038 Read at 32'h4000_0010, PREADY=1 immediately, PRDATA=32'hDEAD_BEEF -> M_rsp_valid at N+3, M_rdata=32'hDEAD_BEEF, M_err=0.
REQ-039 Write 32'h1234_5678 strb 4'b0011 to 32'h7FFF_FFFC, PREADY low 3 ACCESS cycles -> PWDATA/PSTRB stable through ACCESS, M_rsp_valid at N+6, M_err=0, M_rdata=0.
REQ-040 Read at 32'h3FFF_FFFF and at 32'h8000_0000 -> PSEL never high, M_rsp_valid at N+1, M_err=1.
REQ-041 PREADY held 0, TIMEOUT=16 -> PSEL drops after 16 ACCESS cycles, M_err=1; PREADY=1 on the 16th cycle -> normal completion.
REQ-042 PSLVERR=1 with PREADY=1 -> M_err=1; M_rsp_ready held 0 for 5 cycles -> response stable, M_req_ready=0.
REQ-043 rst=1 during ACCESS -> next cycle PSEL=0, PENABLE=0, M_rsp_valid=0, state IDLE.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the APB master bridge and the upstream address decoder.
// Provides the bridge FSM state enum, default APB window/timeout and a range check.
package apb_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [31:0] APB_START_DEF = 32'h4000_0000;
   localparam logic [31:0] APB_END_DEF   = 32'h7FFF_FFFF;
   localparam int unsigned TIMEOUT_DEF   = 16;

   // Unsigned inclusive window test; an end of all-ones cannot wrap.
   function automatic logic in_range(
      input logic [31:0] addr,
      input logic [31:0] lo,
      input logic [31:0] hi
   );
      return (addr >= lo) && (addr <= hi);
   endfunction

endpackage

// File: rtl/apb_wdog.sv
// Wait-state watchdog: counts consecutive stalled ACCESS cycles.
// Ports: clk, rst (sync high), clear, en (stall this cycle), expired (this stall is the last allowed).
module apb_wdog
   import apb_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= 8'd0;
      end else if (en) begin
         cnt <= cnt + 8'd1;
      end
   end

   // Fires during the TIMEOUT-th stalled cycle so the FSM can leave
   // ACCESS at the end of it.
   assign expired = en && (cnt == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Bridges a valid/ready request/response master onto a single APB completer.
// Ports: clk, rst; M_req_* request, M_rsp_* response; P* APB requester signals.
module apb_master_bridge
   import apb_bridge_pkg::*;
#(
   parameter logic [31:0] APB_START = APB_START_DEF,
   parameter logic [31:0] APB_END   = APB_END_DEF,
   parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        M_req_valid,
   output logic        M_req_ready,
   input  logic        M_write,
   input  logic [31:0] M_addr,
   input  logic [31:0] M_wdata,
   input  logic [3:0]  M_strb,
   output logic        M_rsp_valid,
   input  logic        M_rsp_ready,
   output logic [31:0] M_rdata,
   output logic        M_err,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PADDR,
   output logic [31:0] PWDATA,
   output logic [3:0]  PSTRB,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   input  logic        PSLVERR
);

   state_t state;
   state_t state_nxt;
   logic   hs;
   logic   in_rng;
   logic   expired;
   logic   wd_clear;
   logic   wd_en;

   assign in_rng = in_range(M_addr, APB_START, APB_END);
   assign hs     = M_req_valid && M_req_ready;

   apb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .en      (wd_en),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      M_req_ready = 1'b0;
      M_rsp_valid = 1'b0;
      PSEL        = 1'b0;
      PENABLE     = 1'b0;
      wd_clear    = 1'b1;
      wd_en       = 1'b0;
      unique case (state)
         IDLE: begin
            M_req_ready = !rst;
            if (M_req_valid && !rst) begin
               state_nxt = in_rng ? SETUP : RESP;
            end
         end
         SETUP: begin
            PSEL      = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            PSEL     = 1'b1;
            PENABLE  = 1'b1;
            wd_clear = 1'b0;
            wd_en    = !PREADY;
            // PREADY takes priority over an expiring watchdog.
            if (PREADY || expired) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            M_rsp_valid = 1'b1;
            if (M_rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         PWRITE  <= 1'b0;
         PADDR   <= 32'd0;
         PWDATA  <= 32'd0;
         PSTRB   <= 4'd0;
         M_rdata <= 32'd0;
         M_err   <= 1'b0;
      end else begin
         if (hs) begin
            PWRITE  <= M_write;
            PADDR   <= M_addr;
            PWDATA  <= M_wdata;
            PSTRB   <= M_strb;
            M_rdata <= 32'd0;
            M_err   <= !in_rng;
         end
         if (state == ACCESS) begin
            if (PREADY) begin
               M_err   <= PSLVERR;
               // Read data only for successful reads.
               M_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : 32'd0;
            end else if (expired) begin
               M_err   <= 1'b1;
               M_rdata <= 32'd0;
            end
         end
      end
   end

endmodule
